irq_ctrl: RTL and testbench



---
 rtl/irq_pkg.sv | 36 +++
 rtl/irq_ctrl_if.sv | 32 +++
 rtl/irq_prio_enc.sv | 20 ++
 rtl/irq_ctrl.sv | 103 ++++++++++
 tb/tb_irq_ctrl.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// irq_pkg: shared widths, stack-entry layout and vector arithmetic for irq_ctrl.
package irq_pkg;

    // Widest address and level a stack entry can hold (AW <= 64, NCH <= 16).
    localparam int MAX_AW = 64;
    localparam int MAX_LW = 5;

    // Level counts 0..NCH, so it needs room for NCH+1 values.
    function automatic int lvl_w(int nch);
        return $clog2(nch + 1);
    endfunction

    // Stack occupancy counts 0..DEPTH.
    function automatic int dep_w(int depth);
        return $clog2(depth + 1);
    endfunction

    // Channel index width, kept at least one bit for a single channel.
    function automatic int idx_w(int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    // One nesting frame: where to return and which level to restore.
    typedef struct packed {
        logic [MAX_AW-1:0] pc;
        logic [MAX_LW-1:0] lvl;
    } stk_ent_t;

    // Handler address of channel idx; callers truncate to their AW.
    function automatic logic [MAX_AW-1:0] irq_vec(logic [MAX_AW-1:0] base,
                                                   logic [MAX_AW-1:0] stride,
                                                   logic [MAX_AW-1:0] idx);
        return base + idx * stride;
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: core-side request/redirect bundle between the CPU and irq_ctrl.
interface irq_ctrl_if #(
    parameter int NCH   = 3,
    parameter int DEPTH = 2,
    parameter int AW    = 32
);
    localparam int LW = $clog2(NCH + 1);
    localparam int DW = $clog2(DEPTH + 1);

    logic [NCH-1:0] irq_in;
    logic           mask_we;
    logic [NCH-1:0] mask_din;
    logic [AW-1:0]  pc_next;
    logic           eret;
    logic           take;
    logic [AW-1:0]  vector;
    logic [AW-1:0]  epc;
    logic [NCH-1:0] mask;
    logic [NCH-1:0] pending;
    logic [LW-1:0]  level;
    logic [DW-1:0]  depth;

    modport master (
        output irq_in, mask_we, mask_din, pc_next, eret,
        input  take, vector, epc, mask, pending, level, depth
    );

    modport slave (
        input  irq_in, mask_we, mask_din, pc_next, eret,
        output take, vector, epc, mask, pending, level, depth
    );
endinterface

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: fixed-priority encoder, highest set index wins.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter  int NCH = 3,
    localparam int IW  = idx_w(NCH)
) (
    input  logic [NCH-1:0] req,
    output logic           valid,
    output logic [IW-1:0]  idx
);
    // Ascending scan: later (higher) indices overwrite earlier ones.
    always_comb begin
        idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (req[i]) idx = IW'(i);
        end
        valid = |req;
    end
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-latched, maskable, nesting interrupt controller beside the PC mux.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int          NCH        = 3,
    parameter int          DEPTH      = 2,
    parameter int          AW         = 32,
    parameter logic [AW-1:0] VEC_BASE   = AW'('h400),
    parameter logic [AW-1:0] VEC_STRIDE = AW'('h10)
) (
    input  logic     clk,
    input  logic     rst,
    irq_ctrl_if.slave bus
);
    localparam int LW = lvl_w(NCH);
    localparam int DW = dep_w(DEPTH);
    localparam int IW = idx_w(NCH);

    logic [NCH-1:0]    irq_q;
    logic [NCH-1:0]    pending;
    logic [NCH-1:0]    mask;
    logic [DW-1:0]     depth;
    logic [LW-1:0]     level;
    stk_ent_t          stk [DEPTH];

    logic [NCH-1:0]    rise;
    logic [NCH-1:0]    above;
    logic [NCH-1:0]    req;
    logic              gate;
    logic              take;
    logic [IW-1:0]     win;
    logic [NCH-1:0]    clr;
    stk_ent_t          push_ent;
    stk_ent_t          top_ent;
    logic [MAX_AW-1:0] vec_full;
    logic              unused_bits;

    // Eligibility from registered state only; eret and a full stack block every take.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            above[i] = (LW'(i + 1) > level);
        end
        rise = bus.irq_in & ~irq_q;
        gate = (depth < DW'(DEPTH)) & ~bus.eret;
        req  = pending & mask & above & {NCH{gate}};
    end

    irq_prio_enc #(.NCH(NCH)) u_enc (
        .req   (req),
        .valid (take),
        .idx   (win)
    );

    // Frame to push, current top of stack, and the winner's handler address.
    always_comb begin
        push_ent              = '0;
        push_ent.pc[AW-1:0]   = bus.pc_next;
        push_ent.lvl[LW-1:0]  = level;
        top_ent = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (depth == DW'(i + 1)) top_ent = stk[i];
        end
        vec_full = irq_vec(MAX_AW'(VEC_BASE), MAX_AW'(VEC_STRIDE), MAX_AW'(win));
        clr      = take ? (NCH'(1) << win) : '0;
    end

    // Padding bits of the generic stack entry are intentionally not consumed.
    assign unused_bits = &{1'b0, top_ent, vec_full};

    assign bus.take    = take;
    assign bus.vector  = vec_full[AW-1:0];
    assign bus.epc     = top_ent.pc[AW-1:0];
    assign bus.mask    = mask;
    assign bus.pending = pending;
    assign bus.level   = level;
    assign bus.depth   = depth;

    // Edge latch, mask write, and push/pop of the nesting stack.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q   <= '0;
            pending <= '0;
            mask    <= '1;
            depth   <= '0;
            level   <= '0;
            for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
        end else begin
            irq_q   <= bus.irq_in;
            pending <= (pending & ~clr) | rise;
            if (bus.mask_we) mask <= bus.mask_din;
            if (take) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (depth == DW'(i)) stk[i] <= push_ent;
                end
                depth <= depth + DW'(1);
                level <= LW'(win) + LW'(1);
            end else if (bus.eret && depth != '0) begin
                depth <= depth - DW'(1);
                level <= top_ent.lvl[LW-1:0];
            end
        end
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed plus random stimulus against a queue-based reference model.
module tb_irq_ctrl;
    localparam int NCH   = 3;
    localparam int DEPTH = 2;
    localparam int AW    = 32;

    typedef struct {
        logic        take;
        logic [31:0] vector;
        logic [31:0] epc;
        logic [2:0]  mask;
        logic [2:0]  pending;
        int          level;
        int          depth;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        int          lvl;
    } frame_t;

    logic clk = 1'b0;
    logic rst;

    irq_ctrl_if #(.NCH(NCH), .DEPTH(DEPTH), .AW(AW)) bus ();

    irq_ctrl #(
        .NCH(NCH), .DEPTH(DEPTH), .AW(AW),
        .VEC_BASE(32'h400), .VEC_STRIDE(32'h10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    exp_t exp_q[$];

    // Reference model: plain bit vectors, an integer level and a queue as the stack.
    logic [2:0] m_irq_q, m_pend, m_mask;
    int         m_lvl;
    frame_t     m_stk[$];

    task automatic model_reset();
        m_irq_q = '0; m_pend = '0; m_mask = 3'b111; m_lvl = 0;
        m_stk.delete();
    endtask

    task automatic dchk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h want %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Drive one cycle's inputs, record the outputs the model predicts, then advance the model.
    task automatic drv(input logic [2:0] irq, input logic mwe, input logic [2:0] mdin,
                       input logic [31:0] pc, input logic er, input logic r);
        exp_t  e;
        int    win;
        frame_t f;
        logic [2:0] rise;
        bus.irq_in = irq; bus.mask_we = mwe; bus.mask_din = mdin;
        bus.pc_next = pc; bus.eret = er; rst = r;
        win = -1;
        for (int i = 0; i < NCH; i++)
            if (m_pend[i] && m_mask[i] && (i + 1 > m_lvl) && (m_stk.size() < DEPTH) && !er)
                win = i;
        e.take    = (win >= 0);
        e.vector  = 32'h400 + 32'(win) * 32'h10;
        e.epc     = (m_stk.size() > 0) ? m_stk[$].pc : 32'h0;
        e.mask    = m_mask;
        e.pending = m_pend;
        e.level   = m_lvl;
        e.depth   = m_stk.size();
        e.cyc     = cyc;
        exp_q.push_back(e);
        if (r) begin
            model_reset();
        end else begin
            rise    = irq & ~m_irq_q;
            m_irq_q = irq;
            if (win >= 0) begin
                f.pc = pc; f.lvl = m_lvl;
                m_stk.push_back(f);
                m_lvl = win + 1;
                m_pend[win] = 1'b0;
            end else if (er && m_stk.size() > 0) begin
                f = m_stk.pop_back();
                m_lvl = f.lvl;
            end
            m_pend = m_pend | rise;
            if (mwe) m_mask = mdin;
        end
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drv(3'b000, 1'b0, 3'b111, 32'h0, 1'b0, 1'b0);
            step();
        end
    endtask

    // Monitor: every cycle the DUT presents a full set of outputs; compare against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.take !== e.take || (e.take && bus.vector !== e.vector) ||
                    bus.epc !== e.epc || bus.mask !== e.mask || bus.pending !== e.pending ||
                    32'(bus.level) !== 32'(e.level) || 32'(bus.depth) !== 32'(e.depth)) begin
                    errors++;
                    $display("FAIL sb cycle %0d got take=%0b vec=%0h epc=%0h mask=%0b pend=%0b lvl=%0d dep=%0d want take=%0b vec=%0h epc=%0h mask=%0b pend=%0b lvl=%0d dep=%0d",
                             e.cyc, bus.take, bus.vector, bus.epc, bus.mask, bus.pending, bus.level, bus.depth,
                             e.take, e.vector, e.epc, e.mask, e.pending, e.level, e.depth);
                end
            end
        end
    end

    initial begin
        logic [2:0]  irq;
        logic [31:0] r;
        int          n;
        bus.irq_in = '0; bus.mask_we = 1'b0; bus.mask_din = '1;
        bus.pc_next = '0; bus.eret = 1'b0; rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        drv(3'b000, 1'b0, 3'b111, 32'h0, 1'b0, 1'b0);
        dchk("rst_take", 32'(bus.take), 32'h0);
        dchk("rst_epc", bus.epc, 32'h0);
        dchk("rst_mask", 32'(bus.mask), 32'h7);
        step();

        // ch0 request, then nest ch2, then unwind
        drv(3'b001, 1'b0, 3'b111, 32'h10, 1'b0, 1'b0); step();
        drv(3'b001, 1'b0, 3'b111, 32'h20, 1'b0, 1'b0);
        dchk("s1_take", 32'(bus.take), 32'h1);
        dchk("s1_vec", bus.vector, 32'h400);
        step();
        drv(3'b001, 1'b0, 3'b111, 32'h24, 1'b0, 1'b0);
        dchk("s1_epc", bus.epc, 32'h20);
        dchk("s1_lvl", 32'(bus.level), 32'h1);
        dchk("s1_dep", 32'(bus.depth), 32'h1);
        dchk("s1_pend", 32'(bus.pending), 32'h0);
        step();
        drv(3'b101, 1'b0, 3'b111, 32'h300, 1'b0, 1'b0); step();
        drv(3'b101, 1'b0, 3'b111, 32'h404, 1'b0, 1'b0);
        dchk("s2_vec", bus.vector, 32'h420);
        step();
        drv(3'b101, 1'b0, 3'b111, 32'h0, 1'b0, 1'b0);
        dchk("s2_dep", 32'(bus.depth), 32'h2);
        dchk("s2_epc", bus.epc, 32'h404);
        step();
        drv(3'b101, 1'b0, 3'b111, 32'h0, 1'b1, 1'b0); step();
        drv(3'b101, 1'b0, 3'b111, 32'h0, 1'b0, 1'b0);
        dchk("s2_epc_pop", bus.epc, 32'h20);
        dchk("s2_lvl_pop", 32'(bus.level), 32'h1);
        step();
        drv(3'b101, 1'b0, 3'b111, 32'h0, 1'b1, 1'b0); step();
        drv(3'b000, 1'b0, 3'b111, 32'h0, 1'b0, 1'b0);
        dchk("s2_dep0", 32'(bus.depth), 32'h0);
        dchk("s2_lvl0", 32'(bus.level), 32'h0);
        step();

        // Lower priority blocked in ch2 handler; eret and eligible request in the same cycle
        drv(3'b100, 1'b0, 3'b111, 32'h0, 1'b0, 1'b0); step();
        drv(3'b100, 1'b0, 3'b111, 32'h80, 1'b0, 1'b0); step();
        drv(3'b110, 1'b0, 3'b111, 32'h0, 1'b0, 1'b0); step();
        drv(3'b110, 1'b0, 3'b111, 32'h0, 1'b0, 1'b0);
        dchk("s3_blocked", 32'(bus.take), 32'h0);
        dchk("s3_pend", 32'(bus.pending), 32'h2);
        step();
        drv(3'b110, 1'b0, 3'b111, 32'h0, 1'b1, 1'b0);
        dchk("s3_eret_wins", 32'(bus.take), 32'h0);
        step();
        drv(3'b110, 1'b0, 3'b111, 32'h0, 1'b0, 1'b0);
        dchk("s3_take", 32'(bus.take), 32'h1);
        dchk("s3_vec", bus.vector, 32'h410);
        step();
        drv(3'b000, 1'b0, 3'b111, 32'h0, 1'b1, 1'b0); step();
        idle(1);

        // Masked channel stays pending until unmasked
        drv(3'b000, 1'b1, 3'b110, 32'h0, 1'b0, 1'b0); step();
        drv(3'b001, 1'b0, 3'b111, 32'h0, 1'b0, 1'b0); step();
        drv(3'b000, 1'b0, 3'b111, 32'h0, 1'b0, 1'b0);
        dchk("s4_pend", 32'(bus.pending), 32'h1);
        dchk("s4_masked", 32'(bus.take), 32'h0);
        step();
        drv(3'b000, 1'b1, 3'b111, 32'h0, 1'b0, 1'b0);
        dchk("s4_wr_cycle", 32'(bus.take), 32'h0);
        step();
        drv(3'b000, 1'b0, 3'b111, 32'h0, 1'b0, 1'b0);
        dchk("s4_take", 32'(bus.take), 32'h1);
        dchk("s4_vec", bus.vector, 32'h400);
        step();
        drv(3'b000, 1'b0, 3'b111, 32'h0, 1'b1, 1'b0); step();

        // Full stack blocks even the highest priority
        drv(3'b001, 1'b0, 3'b111, 32'h0, 1'b0, 1'b0); step();
        drv(3'b001, 1'b0, 3'b111, 32'h40, 1'b0, 1'b0); step();
        drv(3'b011, 1'b0, 3'b111, 32'h0, 1'b0, 1'b0); step();
        drv(3'b011, 1'b0, 3'b111, 32'h44, 1'b0, 1'b0);
        dchk("s5_vec1", bus.vector, 32'h410);
        step();
        drv(3'b111, 1'b0, 3'b111, 32'h0, 1'b0, 1'b0); step();
        drv(3'b111, 1'b0, 3'b111, 32'h0, 1'b0, 1'b0);
        dchk("s5_full", 32'(bus.take), 32'h0);
        dchk("s5_dep", 32'(bus.depth), 32'h2);
        step();
        drv(3'b111, 1'b0, 3'b111, 32'h0, 1'b1, 1'b0); step();
        drv(3'b111, 1'b0, 3'b111, 32'h0, 1'b0, 1'b0);
        dchk("s5_take", 32'(bus.take), 32'h1);
        dchk("s5_vec2", bus.vector, 32'h420);
        step();
        drv(3'b000, 1'b0, 3'b111, 32'h0, 1'b1, 1'b0); step();
        drv(3'b000, 1'b0, 3'b111, 32'h0, 1'b1, 1'b0); step();
        drv(3'b000, 1'b0, 3'b111, 32'h0, 1'b1, 1'b0);
        dchk("s5_dep0", 32'(bus.depth), 32'h0);
        step();
        drv(3'b000, 1'b0, 3'b111, 32'h0, 1'b0, 1'b0);
        dchk("s5_eret0_dep", 32'(bus.depth), 32'h0);
        dchk("s5_eret0_lvl", 32'(bus.level), 32'h0);
        step();

        // Reset in the middle of a handler
        drv(3'b001, 1'b0, 3'b111, 32'h0, 1'b0, 1'b0); step();
        drv(3'b001, 1'b0, 3'b111, 32'h60, 1'b0, 1'b0); step();
        drv(3'b000, 1'b1, 3'b010, 32'h0, 1'b0, 1'b0);
        dchk("s6_dep1", 32'(bus.depth), 32'h1);
        step();
        drv(3'b000, 1'b0, 3'b111, 32'h0, 1'b0, 1'b1); step();
        drv(3'b000, 1'b0, 3'b111, 32'h0, 1'b0, 1'b0);
        dchk("s6_dep", 32'(bus.depth), 32'h0);
        dchk("s6_epc", bus.epc, 32'h0);
        dchk("s6_mask", 32'(bus.mask), 32'h7);
        step();

        // Random traffic
        irq = '0;
        for (int k = 0; k < 3000; k++) begin
            r   = $urandom;
            irq = irq ^ (r[2:0] & r[5:3]);
            n   = m_stk.size();
            drv(irq, ($urandom_range(0, 15) == 0), 3'($urandom),
                $urandom & 32'hFFFF_FFFC,
                (n > 0) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 299) == 0));
            step();
        end

        // Let the monitor drain, bounded
        n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d left want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
